// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants and types used by the mini-cpu blocks.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REG_IDX_W    = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage : riscv_pkg

// File: rtl/register_file.sv
// RISC-V integer register file: x1..x31 storage, two combinational read ports,
// one synchronous write port. x0 has no storage and always reads zero.
module register_file
  import riscv_pkg::*;
#(
  parameter int unsigned xlen = XLEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [xlen-1:0]      rs1_data,
  output logic [xlen-1:0]      rs2_data,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [xlen-1:0]      rd_data,
  input  logic                 write_en
);

  logic [xlen-1:0] regs_q [1:NUM_REGS-1];
  logic [xlen-1:0] regs_d [1:NUM_REGS-1];

  // Index 0 never matches a storage slot, so reads of x0 fall through to zero.
  function automatic logic [xlen-1:0] read_port(input logic [REG_IDX_W-1:0] idx);
    logic [xlen-1:0] result;
    result = {xlen{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == reg_idx_t'(i)) begin
        result = regs_q[i];
      end
    end
    return result;
  endfunction

  // Next-state: write decode; rd=0 has no slot so it is dropped naturally.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (write_en && (rd == reg_idx_t'(i))) begin
        regs_d[i] = rd_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Storage: asynchronous reset wins over any concurrent write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {xlen{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: no bypass, so a same-cycle write shows only after the edge.
  always_comb begin
    rs1_data = read_port(rs1);
    rs2_data = read_port(rs2);
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: behavioural model plus directed vectors.
module tb_register_file;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_data;
  logic            write_en;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  logic [XLEN-1:0] model [32];

  register_file #(.xlen(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd       (rd),
    .rd_data  (rd_data),
    .write_en (write_en)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Architectural model: 32 words, x0 forced to zero on read, reset clears all.
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
  end

  always @(posedge rst) begin
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
  end

  always @(posedge clk) begin
    if (!rst && write_en && rd != 5'd0) model[rd] = rd_data;
  end

  function automatic logic [XLEN-1:0] model_read(input logic [4:0] idx);
    if (rst || idx == 5'd0) return 64'd0;
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from both clock edges.
  always @(negedge clk) begin
    #3;
    if (cmp_on) begin
      chk("model_rs1", rs1_data, model_read(rs1));
      chk("model_rs2", rs2_data, model_read(rs2));
    end
  end

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      chk({name, "_rs1"}, rs1_data, 64'd0);
      chk({name, "_rs2"}, rs2_data, 64'd0);
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [XLEN-1:0] val);
    @(negedge clk);
    rd       = idx;
    rd_data  = val;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    rs1      = 5'd0;
    rs2      = 5'd0;
    rd       = 5'd0;
    rd_data  = 64'd0;
    write_en = 1'b0;
    #1 rst = 1'b1;
    cmp_on = 1'b1;

    // Reset hold, including a write attempt that must be ignored.
    repeat (2) @(posedge clk);
    sweep_zero("reset_hold");
    write_reg(5'd5, 64'd10);
    rs1 = 5'd5;
    rs2 = 5'd5;
    #1;
    chk("reset_write_ignored_rs1", rs1_data, 64'd0);
    chk("reset_write_ignored_rs2", rs2_data, 64'd0);
    sweep_zero("reset_after_write");

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep_zero("post_reset");

    // Full write sweep: x[n] = n+1, with rd=0 expected to be dropped.
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      rd       = 5'(n);
      rd_data  = 64'(n + 1);
      write_en = 1'b1;
    end
    @(negedge clk);
    write_en = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      rs1 = 5'(n);
      rs2 = 5'(n);
      #1;
      chk("sweep_rs1", rs1_data, (n == 0) ? 64'd0 : 64'(n + 1));
      chk("sweep_rs2", rs2_data, (n == 0) ? 64'd0 : 64'(n + 1));
    end
    rs1 = 5'd2;
    rs2 = 5'd31;
    #1;
    chk("pin_x2", rs1_data, 64'd3);
    chk("pin_x31", rs2_data, 64'd32);

    // Read-during-write: old value before the edge, new value after it.
    @(negedge clk);
    rs1      = 5'd7;
    rs2      = 5'd7;
    rd       = 5'd7;
    rd_data  = 64'hDEAD;
    write_en = 1'b1;
    #1;
    chk("rdw_before_edge", rs1_data, 64'd8);
    @(posedge clk);
    #1;
    chk("rdw_after_edge_rs1", rs1_data, 64'hDEAD);
    chk("rdw_after_edge_rs2", rs2_data, 64'hDEAD);
    @(negedge clk);
    write_en = 1'b0;
    write_reg(5'd7, 64'd8);

    // Mid-run asynchronous reset, asserted between edges with a write pending.
    @(negedge clk);
    rs1      = 5'd5;
    rs2      = 5'd7;
    rd       = 5'd9;
    rd_data  = 64'h1234;
    write_en = 1'b1;
    #1;
    chk("pre_reset_x5", rs1_data, 64'd6);
    chk("pre_reset_x7", rs2_data, 64'd8);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      chk("async_reset_rs1", rs1_data, 64'd0);
      chk("async_reset_rs2", rs2_data, 64'd0);
    end
    @(negedge clk);
    write_en = 1'b0;
    @(negedge clk);
    sweep_zero("mid_reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // Full-width data on both ports simultaneously.
    write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    write_reg(5'd1, 64'h8000_0000_0000_0000);
    rs1 = 5'd31;
    rs2 = 5'd1;
    #1;
    chk("wide_rs1_x31", rs1_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wide_rs2_x1", rs2_data, 64'h8000_0000_0000_0000);
    rs1 = 5'd1;
    rs2 = 5'd31;
    #1;
    chk("wide_rs1_x1", rs1_data, 64'h8000_0000_0000_0000);
    chk("wide_rs2_x31", rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);
    rs1 = 5'd0;
    #1;
    chk("x0_still_zero", rs1_data, 64'd0);

    repeat (2) @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file
